// File: rtl/serial_alu_pkg.sv
// Shared types and helpers for the bit-serial ALU: FSM states, opsel encodings
// and the per-operation initial carry.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Arithmetic-mode opsel encodings (opsel[2]=1 means PASS op1)
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_PASS = 3'b100;

  // Logic-mode opsel encodings
  localparam logic [2:0] LOP_AND  = 3'b000;
  localparam logic [2:0] LOP_OR   = 3'b001;
  localparam logic [2:0] LOP_XOR  = 3'b010;
  localparam logic [2:0] LOP_NOT  = 3'b011;
  localparam logic [2:0] LOP_PASS = 3'b100;

  function automatic logic cin0(input logic mode, input logic [2:0] opsel);
    logic c;
    c = 1'b0;
    if (mode && !opsel[2]) begin
      case (opsel)
        OP_SUB, OP_INC: c = 1'b1;
        default:        c = 1'b0;
      endcase
    end else begin
      c = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/serial_alu_seq_bit_slice.sv
// One-bit ALU slice: full adder with per-op operand B selection in arithmetic
// mode, plain bitwise functions with a zero carry in logic mode.
module alu_bit_slice
  import serial_alu_pkg::*;
(
  input  logic       i_op1_bit,
  input  logic       i_op2_bit,
  input  logic       i_cin,
  input  logic       i_mode,
  input  logic [2:0] i_opsel,
  output logic       o_res,
  output logic       o_cout
);

  logic w_b;

  // Slice datapath; PASS in either mode forwards op1 with no carry
  always_comb begin
    w_b    = 1'b0;
    o_res  = i_op1_bit;
    o_cout = 1'b0;
    if (i_mode) begin
      if (i_opsel[2]) begin
        o_res  = i_op1_bit;
        o_cout = 1'b0;
      end else begin
        case (i_opsel)
          OP_ADD:  w_b = i_op2_bit;
          OP_SUB:  w_b = ~i_op2_bit;
          OP_INC:  w_b = 1'b0;
          OP_DEC:  w_b = 1'b1;
          default: w_b = 1'b0;
        endcase
        o_res  = i_op1_bit ^ w_b ^ i_cin;
        o_cout = (i_op1_bit & w_b) | (i_cin & (i_op1_bit ^ w_b));
      end
    end else begin
      case (i_opsel)
        LOP_AND: o_res = i_op1_bit & i_op2_bit;
        LOP_OR:  o_res = i_op1_bit | i_op2_bit;
        LOP_XOR: o_res = i_op1_bit ^ i_op2_bit;
        LOP_NOT: o_res = ~i_op1_bit;
        default: o_res = i_op1_bit;
      endcase
      o_cout = 1'b0;
    end
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: one result bit per cycle, LSB first, through a single
// alu_bit_slice. Optional zero flag output enabled by SERIAL_ALU_ZERO_FLAG_EN.
module serial_alu_seq
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             mode,
  input  logic [2:0]       opsel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IDXW = $clog2(WIDTH + 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;
  logic             r_mode;
  logic [2:0]       r_opsel;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic             r_zero;
`endif

  logic w_slice_res;
  logic w_slice_cout;

  alu_bit_slice u_slice (
    .i_op1_bit (r_op1[r_idx[BW-1:0]]),
    .i_op2_bit (r_op2[r_idx[BW-1:0]]),
    .i_cin     (r_carry),
    .i_mode    (r_mode),
    .i_opsel   (r_opsel),
    .o_res     (w_slice_res),
    .o_cout    (w_slice_cout)
  );

  // Sequencer FSM; the index runs one past the MSB so cout is committed on its own edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op1       <= '0;
      r_op2       <= '0;
      r_mode      <= 1'b0;
      r_opsel     <= 3'b000;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
      r_zero      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_op1      <= op1;
            r_op2      <= op2;
            r_mode     <= mode;
            r_opsel    <= opsel;
            r_carry    <= cin0(mode, opsel);
            r_idx      <= '0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_state    <= ST_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (r_idx == IDXW'(WIDTH)) begin
            r_cout      <= r_carry;
            r_state     <= ST_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            r_zero      <= (r_result == '0);
`endif
          end else begin
            r_result[r_idx[BW-1:0]] <= w_slice_res;
            r_carry                 <= w_slice_cout;
            r_idx                   <= r_idx + IDXW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            r_zero      <= 1'b0;
`endif
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign result    = r_result;
  assign cout      = r_cout;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  assign zero      = r_zero;
`endif

endmodule

// File: tb/tb_serial_alu_seq.sv
// Scoreboard bench for serial_alu_seq (WIDTH=8): stimulus pushes expected
// {cout,result}; a negedge monitor pops on every out_valid && out_ready.
module tb_serial_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         mode;
  logic [2:0]   opsel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic         zero;
`endif

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .mode      (mode),
    .opsel     (opsel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int completions = 0;
  int lat = 0;
  bit track = 1'b0;
  logic [W:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: latency of each accepted op, and scoreboard pop on handshake
  always @(negedge clk) begin
    logic [W:0] e;
    if (track && out_valid) begin
      chk("latency", lat, W + 1);
      track = 1'b0;
    end
    if (track) lat++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_completion: result 0x%0h with empty scoreboard", result);
      end else begin
        e = exp_q.pop_front();
        chk("result", result, e[W-1:0]);
        chk("cout", cout, e[W]);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        chk("zero", zero, (e[W-1:0] == '0));
`endif
        completions++;
      end
    end
    if (in_valid && in_ready) begin
      track = 1'b1;
      lat = 0;
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 40 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: in_ready got 0 expected 1");
    end
  endtask

  task automatic issue(input logic m, input logic [2:0] s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic ec,
                       input bit push);
    wait_ready();
    op1 = a; op2 = b; mode = m; opsel = s; in_valid = 1'b1;
    if (push) exp_q.push_back({ec, er});
    @(posedge clk); #1;
    in_valid = 1'b0;
    op1 = ~a; op2 = W'($urandom); mode = ~m; opsel = ~s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] held;
    int c0;
    rst_n = 1'b0; in_valid = 1'b0; op1 = '0; op2 = '0; mode = 1'b0; opsel = 3'b000;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    chk("rst_zero", zero, 0);
`endif
    rst_n = 1'b1;

    // mode, opsel, op1, op2, expected result, expected cout
    issue(1'b1, 3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("busy_in_run", busy, 1);
    chk("in_ready_in_run", in_ready, 0);
    issue(1'b1, 3'b001, 8'h05, 8'h06, 8'hFF, 1'b0, 1'b1);
    issue(1'b1, 3'b001, 8'h06, 8'h05, 8'h01, 1'b1, 1'b1);
    issue(1'b0, 3'b010, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b1);
    issue(1'b0, 3'b011, 8'h00, 8'h5A, 8'hFF, 1'b0, 1'b1);
    issue(1'b0, 3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b1);
    issue(1'b0, 3'b001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b1);
    issue(1'b0, 3'b100, 8'h96, 8'hFF, 8'h96, 1'b0, 1'b1);
    issue(1'b1, 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    issue(1'b1, 3'b011, 8'h01, 8'h77, 8'h00, 1'b1, 1'b1);
    issue(1'b1, 3'b011, 8'h00, 8'h77, 8'hFF, 1'b0, 1'b1);
    issue(1'b1, 3'b110, 8'h3C, 8'hFF, 8'h3C, 1'b0, 1'b1);

    // Back-pressure in DONE with in_valid high and inputs toggling
    wait_ready();
    out_ready = 1'b0;
    issue(1'b1, 3'b000, 8'h3C, 8'h11, 8'h4D, 1'b0, 1'b1);
    for (int i = 0; i < 40 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("hold_reached_done", out_valid, 1);
    held = result;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op1 = W'($urandom); op2 = W'($urandom); mode = i[0]; opsel = 3'(i);
      @(posedge clk); #1;
      chk("hold_result", result, held);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    c0 = completions;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_valid", out_valid, 0);
    chk("hold_single_completion", completions, c0 + 1);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_no_extra", completions, c0 + 1);

    // Reset while running bit 4 of INC 0xFF: no result must appear
    issue(1'b1, 3'b010, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_cout", cout, 0);
    rst_n = 1'b1;
    c0 = completions;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_completion", completions, c0);
    issue(1'b1, 3'b010, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1);

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
